// File: rtl/wasm_fetch_pkg.sv
// wasm_fetch_pkg
// Shared types and constants for the WebAssembly instruction fetch stage:
// the fetch FSM states, the sticky fault codes, the immediate class of an
// opcode and the table that maps opcodes onto those classes.
package wasm_fetch_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_DECODE,
        S_OUT,
        S_FAULT
    } state_e;

    typedef enum logic [1:0] {
        F_NONE      = 2'd0,
        F_BOUNDS    = 2'd1,
        F_MALFORMED = 2'd2
    } fault_e;

    typedef enum logic [1:0] {
        IMM_NONE,
        IMM_ULEB,
        IMM_SLEB
    } imm_class_e;

    localparam logic [7:0] OP_BR         = 8'h0C;
    localparam logic [7:0] OP_BR_IF      = 8'h0D;
    localparam logic [7:0] OP_CALL       = 8'h10;
    localparam logic [7:0] OP_LOCAL_GET  = 8'h20;
    localparam logic [7:0] OP_GLOBAL_SET = 8'h24;
    localparam logic [7:0] OP_I32_CONST  = 8'h41;

    // Opcodes 0x20..0x24 are the local/global access group, all ULEB indices.
    function automatic imm_class_e imm_class(input logic [7:0] opcode);
        if (opcode == OP_I32_CONST) begin
            return IMM_SLEB;
        end
        if (opcode == OP_BR || opcode == OP_BR_IF || opcode == OP_CALL ||
            (opcode >= OP_LOCAL_GET && opcode <= OP_GLOBAL_SET)) begin
            return IMM_ULEB;
        end
        return IMM_NONE;
    endfunction

endpackage

// File: rtl/wasm_fetch_unit_leb128_decode.sv
// leb128_decode
// Combinational LEB128 decoder for up to five immediate bytes.
// Ports:
//   bytes_i     [39:0]  byte 1 in [39:32] through byte 5 in [7:0]
//   signed_i            decode as SLEB (sign-extend) instead of ULEB
//   value_o     [31:0]  decoded value
//   len_o       [2:0]   number of LEB bytes consumed (1..5; 5 when unterminated)
//   malformed_o         no terminator, or 5th byte carries bits that do not fit 32 bits
module leb128_decode (
    input  logic [39:0] bytes_i,
    input  logic        signed_i,
    output logic [31:0] value_o,
    output logic [2:0]  len_o,
    output logic        malformed_o
);

    logic [34:0]        raw;
    logic               found;
    logic [5:0]         shamt;
    logic signed [34:0] extended;
    logic [7:0]         lastByte;

    // Gather 7-bit groups up to and including the first byte whose
    // continuation bit is clear.
    always_comb begin
        raw   = '0;
        found = 1'b0;
        len_o = 3'd5;
        for (int k = 0; k < 5; k++) begin
            if (!found) begin
                raw[7*k +: 7] = bytes_i[38-8*k -: 7];
                if (!bytes_i[39-8*k]) begin
                    found = 1'b1;
                    len_o = 3'(k + 1);
                end
            end
        end
    end

    // Sign extension: shift the top payload bit to bit 34, then shift back
    // arithmetically. A five-byte value already spans the full 32 bits.
    always_comb begin
        unique case (len_o)
            3'd1:    shamt = 6'd28;
            3'd2:    shamt = 6'd21;
            3'd3:    shamt = 6'd14;
            3'd4:    shamt = 6'd7;
            default: shamt = 6'd0;
        endcase
        extended = $signed(raw << shamt) >>> shamt;
        value_o  = signed_i ? extended[31:0] : raw[31:0];
    end

    // Bits 32..34 of a five-byte value must be zero (ULEB) or copies of
    // bit 31 (SLEB), otherwise the encoding overflows 32 bits.
    always_comb begin
        lastByte    = bytes_i[7:0];
        malformed_o = !found;
        if (found && len_o == 3'd5) begin
            if (signed_i) begin
                malformed_o = lastByte[6:4] != {3{lastByte[3]}};
            end else begin
                malformed_o = lastByte[6:4] != 3'b000;
            end
        end
    end

endmodule

// File: rtl/wasm_fetch_unit.sv
// wasm_fetch_unit
// Instruction fetch stage sitting in front of the byte ROM. Each instruction
// costs one six-byte window request, a decode cycle and an output cycle where
// {opcode, imm, pc} is offered to the decoder on a valid/ready handshake.
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   start_i, start_pc_i              begin fetching (IDLE or FAULT only)
//   code_lo_i, code_hi_i             legal code window, latched at start
//   redirect_i, redirect_pc_i        abort current fetch, continue at target
//   rom_addr_o/extra_o/lower_o/upper_o  ROM request side
//   rom_data_i, rom_error_i          ROM response, valid in DECODE
//   out_valid_o/ready_i/opcode_o/imm_o/has_imm_o/pc_o  decoder handshake
//   busy_o                           fetch in progress
//   fault_o                          sticky fault: 0 none, 1 bounds, 2 malformed
module wasm_fetch_unit
    import wasm_fetch_pkg::*;
#(
    parameter int AW    = 4,
    parameter int DW    = 8,
    parameter int EXTRA = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [AW:0]             start_pc_i,
    input  logic [AW:0]             code_lo_i,
    input  logic [AW:0]             code_hi_i,
    input  logic                    redirect_i,
    input  logic [AW:0]             redirect_pc_i,
    output logic [AW:0]             rom_addr_o,
    output logic [EXTRA-1:0]        rom_extra_o,
    output logic [AW:0]             rom_lower_o,
    output logic [AW:0]             rom_upper_o,
    input  logic [(2**EXTRA)*DW-1:0] rom_data_i,
    input  logic                    rom_error_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [7:0]              out_opcode_o,
    output logic [31:0]             out_imm_o,
    output logic                    out_has_imm_o,
    output logic [AW:0]             out_pc_o,
    output logic                    busy_o,
    output logic [1:0]              fault_o
);

    state_e      state_q, state_d;
    logic [AW:0] pc_q, lo_q, hi_q, out_pc_q;
    logic [7:0]  opcode_q;
    logic [31:0] imm_q;
    logic        has_imm_q;
    logic [2:0]  len_q;
    fault_e      fault_q;

    logic [7:0]    opcodeByte;
    imm_class_e    immClass;
    logic          hasImm;
    logic [31:0]   lebValue;
    logic [2:0]    lebLen;
    logic          lebMalformed;
    logic [2:0]    instLen;
    logic [AW+1:0] lastAddr;
    logic          boundsErr, malformedErr, decodeErr;
    logic          canStart, takeRedirect, transfer;
    logic          unusedRomBits;

    assign opcodeByte = rom_data_i[47:40];
    assign immClass   = imm_class(opcodeByte);
    assign hasImm     = immClass != IMM_NONE;

    leb128_decode u_leb (
        .bytes_i     (rom_data_i[39:0]),
        .signed_i    (immClass == IMM_SLEB),
        .value_o     (lebValue),
        .len_o       (lebLen),
        .malformed_o (lebMalformed)
    );

    // Last byte address is computed one bit wider so an instruction running
    // past the top of the address space compares above code_hi.
    assign instLen      = hasImm ? lebLen + 3'd1 : 3'd1;
    assign lastAddr     = {1'b0, pc_q} + (AW+2)'(instLen) - (AW+2)'(1);
    assign boundsErr    = rom_error_i || (lastAddr > {1'b0, hi_q});
    assign malformedErr = hasImm && lebMalformed;
    assign decodeErr    = boundsErr || malformedErr;

    assign canStart     = start_i && (state_q == S_IDLE || state_q == S_FAULT);
    assign takeRedirect = redirect_i && busy_o;
    assign transfer     = (state_q == S_OUT) && out_ready_i;
    assign unusedRomBits = ^rom_data_i[(2**EXTRA)*DW-1:48];

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a redirect while busy always restarts at REQ.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start_i) state_d = S_REQ;
            S_REQ:    state_d = S_DECODE;
            S_DECODE: state_d = decodeErr ? S_FAULT : S_OUT;
            S_OUT:    if (out_ready_i) state_d = S_REQ;
            S_FAULT:  if (start_i) state_d = S_REQ;
            default:  state_d = S_IDLE;
        endcase
        if (takeRedirect) begin
            state_d = S_REQ;
        end
    end

    // Outputs decoded from state and registered datapath.
    always_comb begin
        out_valid_o   = state_q == S_OUT;
        busy_o        = (state_q != S_IDLE) && (state_q != S_FAULT);
        rom_addr_o    = pc_q;
        rom_extra_o   = EXTRA'(5);
        rom_lower_o   = lo_q;
        rom_upper_o   = hi_q;
        out_opcode_o  = opcode_q;
        out_imm_o     = imm_q;
        out_has_imm_o = has_imm_q;
        out_pc_o      = out_pc_q;
        fault_o       = fault_q;
    end

    // Datapath. pc holds the opcode address until the transfer so the ROM
    // address stays put under backpressure; a redirect overrides next_pc.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q      <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            out_pc_q  <= '0;
            opcode_q  <= '0;
            imm_q     <= '0;
            has_imm_q <= 1'b0;
            len_q     <= '0;
            fault_q   <= F_NONE;
        end else begin
            if (canStart) begin
                pc_q    <= start_pc_i;
                lo_q    <= code_lo_i;
                hi_q    <= code_hi_i;
                fault_q <= F_NONE;
            end
            if (state_q == S_DECODE && !takeRedirect) begin
                if (boundsErr) begin
                    fault_q <= F_BOUNDS;
                end else if (malformedErr) begin
                    fault_q <= F_MALFORMED;
                end else begin
                    opcode_q  <= opcodeByte;
                    imm_q     <= hasImm ? lebValue : 32'd0;
                    has_imm_q <= hasImm;
                    out_pc_q  <= pc_q;
                    len_q     <= instLen;
                end
            end
            if (transfer) begin
                pc_q <= pc_q + (AW+1)'(len_q);
            end
            if (takeRedirect) begin
                pc_q <= redirect_pc_i;
            end
        end
    end

endmodule
